// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, imem request FSM and the IF/ID pipeline register.
// Latency: a word returned with imem_busy=0 reaches IF/ID one edge later, unless a stall parks it in HOLD.
// Backpressure: a stall holds IF/ID and parks one fetched word in HOLD; imem_busy holds the PC in WAIT.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } hold_buf_t;

    state_t    state, state_nxt;
    logic [31:0] pc, pc_nxt;
    if_id_t    if_id, if_id_nxt;
    hold_buf_t hold_buf, hold_buf_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] buf_pc_plus4;

    assign pc_plus4     = pc + 32'd4;
    assign buf_pc_plus4 = hold_buf.pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            if_id    <= '{instr: NOP_INSTR, pc: 32'd0, pc4: 32'd0, valid: 1'b0};
            hold_buf <= '{instr: NOP_INSTR, pc: 32'd0};
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            if_id    <= if_id_nxt;
            hold_buf <= hold_buf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        if_id_nxt    = if_id;
        hold_buf_nxt = hold_buf;

        if (branch_taken) begin
            // Redirect wins everything; any in-flight or parked word is dropped.
            pc_nxt             = {branch_target[31:2], 2'b00};
            hold_buf_nxt       = '{instr: NOP_INSTR, pc: 32'd0};
            if_id_nxt.instr    = NOP_INSTR;
            if_id_nxt.valid    = 1'b0;
            state_nxt          = FETCH;
        end else begin
            case (state)
                IDLE: state_nxt = FETCH;
                FETCH, WAIT: begin
                    if (imem_busy) begin
                        state_nxt = WAIT;
                        if (!stall) begin
                            if_id_nxt.instr = NOP_INSTR;
                            if_id_nxt.valid = 1'b0;
                        end
                    end else if (stall) begin
                        hold_buf_nxt = '{instr: imem_rdata, pc: pc};
                        pc_nxt       = pc_plus4;
                        state_nxt    = HOLD;
                    end else begin
                        if_id_nxt = '{instr: imem_rdata, pc: pc, pc4: pc_plus4, valid: 1'b1};
                        pc_nxt    = pc_plus4;
                        state_nxt = FETCH;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_nxt = '{instr: hold_buf.instr, pc: hold_buf.pc,
                                      pc4: buf_pc_plus4, valid: 1'b1};
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Request strobes are forced low while reset is asserted, whatever the current state.
    assign imem_addr   = pc;
    assign imem_read   = !reset && ((state == FETCH) || (state == WAIT));
    assign fetch_busy  = !reset && (state == WAIT);
    assign if_id_instr = if_id.instr;
    assign if_id_pc    = if_id.pc;
    assign if_id_pc4   = if_id.pc4;
    assign if_id_valid = if_id.valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, imem wait states, stall/HOLD, branch flush, PC wrap, reset in HOLD.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_busy;
    logic [31:0] imem_rdata;

    logic [31:0] imem_addr, if_id_instr, if_id_pc, if_id_pc4;
    logic        imem_read, if_id_valid, fetch_busy;

    logic [31:0] w_imem_addr, w_if_id_instr, w_if_id_pc, w_if_id_pc4;
    logic        w_imem_read, w_if_id_valid, w_fetch_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory responder: word content encodes its own address.
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_busy(imem_busy), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .imem_read(imem_read), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .fetch_busy(fetch_busy)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_busy(imem_busy), .imem_rdata(imem_rdata),
        .imem_addr(w_imem_addr), .imem_read(w_imem_read), .if_id_instr(w_if_id_instr),
        .if_id_pc(w_if_id_pc), .if_id_pc4(w_if_id_pc4), .if_id_valid(w_if_id_valid),
        .fetch_busy(w_fetch_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic valid);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".pc"},    if_id_pc,    pc);
        chk({tag, ".pc4"},   if_id_pc4,   pc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'd0; imem_busy = 1'b0;
        tick();
        tick();

        // Reset state
        chk_ifid("rst", 32'h0000_0013, 32'd0, 32'd0, 1'b0);
        chk("rst.addr", imem_addr, 32'd0);
        chk("rst.read", {31'd0, imem_read}, 32'd0);
        chk("rst.busy", {31'd0, fetch_busy}, 32'd0);
        chk("rst.wrap_addr", w_imem_addr, 32'hFFFF_FFFC);

        // IDLE cycle, then streaming
        reset = 1'b0;
        #1;
        chk("idle.read", {31'd0, imem_read}, 32'd0);
        tick();
        chk("fetch0.addr", imem_addr, 32'd0);
        chk("fetch0.read", {31'd0, imem_read}, 32'd1);
        chk("fetch0.valid", {31'd0, if_id_valid}, 32'd0);
        tick();
        chk_ifid("s0", 32'hC0DE_0000, 32'd0, 32'd4, 1'b1);
        chk("s0.addr", imem_addr, 32'd4);
        chk("wrap.pc", w_if_id_pc, 32'hFFFF_FFFC);
        chk("wrap.pc4", w_if_id_pc4, 32'd0);
        chk("wrap.addr", w_imem_addr, 32'd0);
        tick();
        chk_ifid("s4", 32'hC0DE_0004, 32'd4, 32'd8, 1'b1);
        chk("s4.addr", imem_addr, 32'd8);

        // imem busy for three cycles at pc 8
        imem_busy = 1'b1;
        #1;
        chk("b0.fbusy", {31'd0, fetch_busy}, 32'd0);
        tick();
        chk("b1.fbusy", {31'd0, fetch_busy}, 32'd1);
        chk_ifid("b1", 32'h0000_0013, 32'd4, 32'd8, 1'b0);
        chk("b1.addr", imem_addr, 32'd8);
        tick();
        chk("b2.fbusy", {31'd0, fetch_busy}, 32'd1);
        chk("b2.read", {31'd0, imem_read}, 32'd1);
        tick();
        chk("b3.fbusy", {31'd0, fetch_busy}, 32'd1);
        chk("b3.valid", {31'd0, if_id_valid}, 32'd0);
        imem_busy = 1'b0;
        tick();
        chk_ifid("s8", 32'hC0DE_0008, 32'd8, 32'd12, 1'b1);
        chk("s8.fbusy", {31'd0, fetch_busy}, 32'd0);
        chk("s8.addr", imem_addr, 32'd12);

        // Stall for two cycles while fetch of pc C completes
        stall = 1'b1;
        tick();
        chk_ifid("h1", 32'hC0DE_0008, 32'd8, 32'd12, 1'b1);
        chk("h1.read", {31'd0, imem_read}, 32'd0);
        chk("h1.addr", imem_addr, 32'h10);
        tick();
        chk_ifid("h2", 32'hC0DE_0008, 32'd8, 32'd12, 1'b1);
        stall = 1'b0;
        tick();
        chk_ifid("sC", 32'hC0DE_000C, 32'hC, 32'h10, 1'b1);
        chk("sC.addr", imem_addr, 32'h10);
        chk("sC.read", {31'd0, imem_read}, 32'd1);

        // Branch to 0x103 while waiting on pc 0x10
        imem_busy = 1'b1;
        tick();
        chk("w.fbusy", {31'd0, fetch_busy}, 32'd1);
        branch_taken = 1'b1; branch_target = 32'h103;
        tick();
        branch_taken = 1'b0; imem_busy = 1'b0;
        #1;
        chk("br.addr", imem_addr, 32'h100);
        chk("br.fbusy", {31'd0, fetch_busy}, 32'd0);
        chk_ifid("br", 32'h0000_0013, 32'hC, 32'h10, 1'b0);
        tick();
        chk_ifid("s100", 32'hC0DE_0100, 32'h100, 32'h104, 1'b1);

        // Branch beats a simultaneous stall
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        #1;
        chk("brst.addr", imem_addr, 32'h200);
        chk("brst.valid", {31'd0, if_id_valid}, 32'd0);
        tick();
        chk_ifid("s200", 32'hC0DE_0200, 32'h200, 32'h204, 1'b1);

        // Reset while parked in HOLD
        stall = 1'b1;
        tick();
        chk("hr.read", {31'd0, imem_read}, 32'd0);
        chk("hr.addr", imem_addr, 32'h208);
        reset = 1'b1;
        tick();
        chk_ifid("hr.rst", 32'h0000_0013, 32'd0, 32'd0, 1'b0);
        chk("hr.rst.addr", imem_addr, 32'd0);
        chk("hr.rst.read", {31'd0, imem_read}, 32'd0);
        reset = 1'b0; stall = 1'b0;
        tick();
        chk_ifid("hr.idle", 32'h0000_0013, 32'd0, 32'd0, 1'b0);
        tick();
        chk_ifid("hr.s0", 32'hC0DE_0000, 32'd0, 32'd4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, the PC loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, the instruction word driven into IF/ID on a bubble or flush.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hazard-unit stall; hold the IF/ID register and PC advance.
REQ-007 branch_taken  input  1  redirect request from EX.
REQ-008 branch_target  input  32  redirect address.
REQ-009 imem_busy  input  1  instruction memory not ready this cycle.
REQ-010 imem_rdata  input  32  instruction word, valid when imem_read=1 and imem_busy=0.
REQ-011 imem_addr  output  32  fetch address; equals the PC register in every state.
REQ-012 imem_read  output  1  fetch request strobe.
REQ-013 if_id_instr  output  32  registered instruction to ID.
REQ-014 if_id_pc  output  32  registered PC of if_id_instr.
REQ-015 if_id_pc4  output  32  registered if_id_pc+4.
REQ-016 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 fetch_busy  output  1  high while in the WAIT state.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, WAIT and HOLD; imem_read=1 only in FETCH and WAIT.
REQ-019 IDLE SHALL move to FETCH on the next edge unconditionally, with no IF/ID change.
REQ-020 In FETCH or WAIT with imem_busy=0 and stall=0: IF/ID <= {imem_rdata, pc, pc+4, valid=1}, pc <= pc+4, next state FETCH.
REQ-021 In FETCH or WAIT with imem_busy=0 and stall=1: buf_instr <= imem_rdata, buf_pc <= pc, pc <= pc+4, IF/ID held, next state HOLD.
REQ-022 In FETCH or WAIT with imem_busy=1: next state WAIT, pc held; IF/ID <= bubble (NOP_INSTR, valid=0, pc fields held) if stall=0, else IF/ID held.
REQ-023 In HOLD with stall=0: IF/ID <= {buf_instr, buf_pc, buf_pc+4, valid=1}, next state FETCH; with stall=1, remain in HOLD with everything held.
REQ-024 branch_taken=1 SHALL take priority over stall and imem_busy in every state: pc <= {branch_target[31:2], 2'b00}, buffer discarded, IF/ID <= bubble, next state FETCH.
REQ-025 An outstanding WAIT fetch abandoned by a branch SHALL be dropped; no stale word enters IF/ID.
REQ-026 PC and pc+4 arithmetic is modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 Latency: an instruction reaches IF/ID one edge after the cycle it is returned with imem_busy=0, when stall=0.
REQ-028 Instruction order SHALL be preserved, with no instruction lost or duplicated except through a branch flush.

Reset
REQ-029 On reset=1 at an edge: pc=RESET_PC, state=IDLE, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, if_id_valid=0, buffer cleared.
REQ-030 During reset and the IDLE cycle: imem_read=0, fetch_busy=0.
REQ-031 Reset SHALL override branch_taken, stall and any in-flight fetch, including reset asserted mid-WAIT or mid-HOLD.

Verification
REQ-032 Reset, then stream with busy=0 and stall=0 -> imem_addr 0,4,8; IF/ID shows pc 0,4,8, valid=1 on consecutive cycles starting two edges after reset release.
REQ-033 imem_busy=1 for 3 cycles at pc=8 -> fetch_busy=1 for 3 cycles; IF/ID bubble (valid=0, NOP_INSTR); then pc 8 instruction enters IF/ID.
REQ-034 stall=1 for 2 cycles while fetch of pc=C completes -> HOLD entered, IF/ID unchanged; stall drop -> IF/ID pc=C, next fetch address 0x10.
REQ-035 branch_taken with target 0x103 while in WAIT -> next imem_addr=0x100; IF/ID valid=0; the late busy-drop word is not captured.
REQ-036 RESET_PC=32'hFFFF_FFFC, one fetch -> if_id_pc4=0, next imem_addr=0.
REQ-037 Reset asserted in HOLD -> all outputs at reset values next cycle; buffered word never appears.
